frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader_pkg.sv | 31 +++
 rtl/frame_reader_fifo.sv | 59 +++++
 rtl/frame_reader.sv | 236 +++++++++++++++++++++++
 tb/tb_frame_reader.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader: FSM states, CI command codes and sizing.
package frame_reader_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REQUEST_BUS = 3'd1,
        INIT_BURST  = 3'd2,
        WAIT_DATA   = 3'd3,
        END_BURST   = 3'd4,
        ERROR       = 3'd5
    } frameState_t;

    localparam logic [2:0] CMD_WRITE_BASE  = 3'd0;
    localparam logic [2:0] CMD_WRITE_WPL   = 3'd1;
    localparam logic [2:0] CMD_WRITE_LINES = 3'd2;
    localparam logic [2:0] CMD_CONTROL     = 3'd3;
    localparam logic [2:0] CMD_READ_STATUS = 3'd4;
    localparam logic [2:0] CMD_READ_BASE   = 3'd5;

    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;

    // Length of the next burst: never more than MAX_BURST, never past the end of the line.
    function automatic logic [4:0] burstLength(input logic [8:0] wordsLeft);
        if (wordsLeft >= 9'(MAX_BURST)) begin
            return 5'(MAX_BURST);
        end
        return wordsLeft[4:0];
    endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// 32 x 32-bit synchronous FIFO with occupancy count and flush.
module frame_reader_fifo
    import frame_reader_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        flush_i,
    input  logic        wrEn_i,
    input  logic [31:0] wrData_i,
    input  logic        rdEn_i,
    output logic [31:0] rdData_o,
    output logic        empty_o,
    output logic [5:0]  count_o
);

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [4:0]  wrPtr_q;
    logic [4:0]  rdPtr_q;
    logic [5:0]  count_q;
    logic        full;
    logic        doWrite;
    logic        doRead;

    assign empty_o  = (count_q == 6'd0);
    assign full     = (count_q == 6'(FIFO_DEPTH));
    assign doRead   = rdEn_i && !empty_o;
    assign doWrite  = wrEn_i && (!full || doRead);
    assign count_o  = count_q;
    assign rdData_o = empty_o ? 32'd0 : mem_q[rdPtr_q];

    // Storage array; contents need no reset because the count guards every read.
    always_ff @(posedge clock_i) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous read and write leaves the count alone.
    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            wrPtr_q <= 5'd0;
            rdPtr_q <= 5'd0;
            count_q <= 6'd0;
        end else begin
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + 5'd1;
            end
            if (doRead) begin
                rdPtr_q <= rdPtr_q + 5'd1;
            end
            case ({doWrite, doRead})
                2'b10:   count_q <= count_q + 6'd1;
                2'b01:   count_q <= count_q - 6'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Frame reader: bursts a frame of grey pixels out of memory into a pixel stream,
// configured, started and monitored through custom-instruction calls.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        requestBus,
    input  logic        busGrant,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        readNotWriteOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic [31:0] addressDataOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn,
    output logic [31:0] pixelWord,
    output logic        pixelValid,
    input  logic        pixelReady
);

    frameState_t state_q;
    frameState_t state_d;

    logic        ciSelected;
    logic [2:0]  ciCommand;
    logic        startCmd;
    logic        abortCmd;
    logic        unusedCiBits;

    logic [31:0] base_q;
    logic [8:0]  wordsPerLine_q;
    logic [10:0] nrOfLines_q;
    logic [31:0] address_q;
    logic [8:0]  lineRemain_q;
    logic [10:0] linesLeft_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        discard_q;

    logic        beginTransaction_q;
    logic        readNotWrite_q;
    logic [3:0]  byteEnables_q;
    logic [7:0]  burstSize_q;
    logic [31:0] addressData_q;

    logic [8:0]  wplEffective;
    logic [4:0]  burstLen;
    logic [5:0]  fifoCount;
    logic [5:0]  freeEntries;
    logic        fifoEmpty;
    logic        fifoWrite;
    logic        fifoRead;
    logic        fifoFlush;
    logic        beatAccepted;

    assign ciSelected   = ciStart && ciCke && (ciN == customInstructionId);
    assign ciDone       = ciSelected;
    assign ciCommand    = ciValueA[2:0];
    assign startCmd     = ciSelected && (ciCommand == CMD_CONTROL) && ciValueB[0];
    assign abortCmd     = ciSelected && (ciCommand == CMD_CONTROL) && ciValueB[1];
    assign unusedCiBits = ^ciValueA[31:3];

    assign wplEffective = (wordsPerLine_q == 9'd0) ? 9'd256 : wordsPerLine_q;
    assign burstLen     = burstLength(lineRemain_q);
    assign freeEntries  = 6'(FIFO_DEPTH) - fifoCount;

    // A beat that errors is dropped; beats of an aborted burst are counted but not stored.
    assign beatAccepted = (state_q == WAIT_DATA) && dataValidIn && !busErrorIn;
    assign fifoWrite    = beatAccepted && !discard_q;
    assign fifoRead     = pixelValid && pixelReady;
    assign fifoFlush    = abortCmd || (discard_q && (state_d == IDLE));

    assign pixelValid          = !fifoEmpty;
    assign requestBus          = (state_q == REQUEST_BUS);
    assign endTransactionOut   = (state_q == ERROR);
    assign beginTransactionOut = beginTransaction_q;
    assign readNotWriteOut     = readNotWrite_q;
    assign byteEnablesOut      = byteEnables_q;
    assign burstSizeOut        = burstSize_q;
    assign addressDataOut      = addressData_q;

    // Custom-instruction read-back mux; anything not selected or not a read returns zero.
    always_comb begin
        ciResult = 32'd0;
        if (ciSelected) begin
            case (ciCommand)
                CMD_READ_STATUS: ciResult = {29'd0, error_q, done_q, busy_q};
                CMD_READ_BASE:   ciResult = base_q;
                default:         ciResult = 32'd0;
            endcase
        end
    end

    // Next-state logic: only ask for the bus when the whole next burst fits in the FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (busy_q && (lineRemain_q != 9'd0) && (freeEntries >= 6'(burstLen))) begin
                    state_d = REQUEST_BUS;
                end
            end
            REQUEST_BUS: begin
                if (busGrant) begin
                    state_d = INIT_BURST;
                end else if (!busy_q) begin
                    state_d = IDLE;
                end
            end
            INIT_BURST: state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (busErrorIn) begin
                    state_d = ERROR;
                end else if (endTransactionIn) begin
                    state_d = END_BURST;
                end
            end
            END_BURST: state_d = IDLE;
            ERROR:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration, frame counters and status; abort is applied last so it always wins busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_q         <= 32'd0;
            wordsPerLine_q <= 9'd0;
            nrOfLines_q    <= 11'd0;
            address_q      <= 32'd0;
            lineRemain_q   <= 9'd0;
            linesLeft_q    <= 11'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            discard_q      <= 1'b0;
        end else begin
            if (ciSelected) begin
                case (ciCommand)
                    CMD_WRITE_BASE:  base_q         <= {ciValueB[31:2], 2'b00};
                    CMD_WRITE_WPL:   wordsPerLine_q <= ciValueB[8:0];
                    CMD_WRITE_LINES: nrOfLines_q    <= ciValueB[10:0];
                    default:         ;
                endcase
            end

            if (startCmd && !abortCmd && !busy_q && !discard_q) begin
                address_q    <= base_q;
                lineRemain_q <= wplEffective;
                linesLeft_q  <= nrOfLines_q;
                error_q      <= 1'b0;
                done_q       <= (nrOfLines_q == 11'd0);
                busy_q       <= (nrOfLines_q != 11'd0);
            end

            if (beatAccepted) begin
                address_q    <= address_q + 32'd4;
                lineRemain_q <= lineRemain_q - 9'd1;
            end

            if ((state_q == END_BURST) && busy_q && (lineRemain_q == 9'd0)) begin
                lineRemain_q <= wplEffective;
                linesLeft_q  <= linesLeft_q - 11'd1;
                if (linesLeft_q == 11'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end

            if (state_q == ERROR) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end

            if (abortCmd) begin
                busy_q    <= 1'b0;
                discard_q <= (state_d != IDLE);
            end else if (state_d == IDLE) begin
                discard_q <= 1'b0;
            end
        end
    end

    // Burst request outputs are loaded during INIT_BURST and held for exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            beginTransaction_q <= 1'b0;
            readNotWrite_q     <= 1'b0;
            byteEnables_q      <= 4'h0;
            burstSize_q        <= 8'd0;
            addressData_q      <= 32'd0;
        end else begin
            beginTransaction_q <= (state_q == INIT_BURST);
            readNotWrite_q     <= (state_q == INIT_BURST);
            byteEnables_q      <= (state_q == INIT_BURST) ? 4'hF : 4'h0;
            burstSize_q        <= (state_q == INIT_BURST) ? {3'd0, burstLen - 5'd1} : 8'd0;
            addressData_q      <= (state_q == INIT_BURST) ? address_q : 32'd0;
        end
    end

    frame_reader_fifo pixelFifo (
        .clock_i  (clock),
        .reset_i  (reset),
        .flush_i  (fifoFlush),
        .wrEn_i   (fifoWrite),
        .wrData_i (addressDataIn),
        .rdEn_i   (fifoRead),
        .rdData_o (pixelWord),
        .empty_o  (fifoEmpty),
        .count_o  (fifoCount)
    );

endmodule

// File: tb/tb_frame_reader.sv
// Testbench for frame_reader: CI vector table plus directed frame, back-pressure,
// bus-error, restart, abort and address-wrap sequences against a simple bus slave model.
module tb_frame_reader;

    localparam logic [7:0]  CI_ID   = 8'h2A;
    localparam logic [31:0] PATTERN = 32'h5A5A_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ciStart, ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        requestBus, busGrant;
    logic        beginTransactionOut, endTransactionOut, readNotWriteOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataOut, addressDataIn;
    logic        dataValidIn, endTransactionIn, busErrorIn;
    logic [31:0] pixelWord;
    logic        pixelValid, pixelReady;

    frame_reader #(.customInstructionId(CI_ID)) dut (
        .clock               (clock),
        .reset               (reset),
        .ciStart             (ciStart),
        .ciCke               (ciCke),
        .ciN                 (ciN),
        .ciValueA            (ciValueA),
        .ciValueB            (ciValueB),
        .ciResult            (ciResult),
        .ciDone              (ciDone),
        .requestBus          (requestBus),
        .busGrant            (busGrant),
        .beginTransactionOut (beginTransactionOut),
        .endTransactionOut   (endTransactionOut),
        .readNotWriteOut     (readNotWriteOut),
        .byteEnablesOut      (byteEnablesOut),
        .burstSizeOut        (burstSizeOut),
        .addressDataOut      (addressDataOut),
        .addressDataIn       (addressDataIn),
        .dataValidIn         (dataValidIn),
        .endTransactionIn    (endTransactionIn),
        .busErrorIn          (busErrorIn),
        .pixelWord           (pixelWord),
        .pixelValid          (pixelValid),
        .pixelReady          (pixelReady)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  n;
        logic        start;
        logic        cke;
        logic [31:0] a;
        logic [31:0] b;
        logic        expDone;
        logic [31:0] expResult;
    } ciVector_t;

    ciVector_t   vectors[13];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          cycleCount = 0;
    logic [31:0] burstAddrQ[$];
    int          burstLenQ[$];
    logic [31:0] expAddrQ[$];
    int          expLenQ[$];
    logic [31:0] rxQ[$];
    int          beatsSeen = 0;
    int          firstBeatCycle = -1;
    int          firstValidCycle = -1;
    int          endPulseCount = 0;
    int          requestCount = 0;
    int          errorOnBeat = -1;
    int          readBudget = 0;
    bit          readyAll = 1'b0;
    logic [31:0] res;

    // Free-running cycle counter used for latency measurement.
    initial begin
        forever begin
            @(posedge clock);
            cycleCount++;
        end
    end

    // Bus slave: grants requests, returns addr^PATTERN per beat, optional error on a beat of the first burst.
    initial begin : busSlave
        logic [31:0] addr;
        int          len;
        bit          errored;
        busGrant = 0; dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0; addressDataIn = 0;
        forever begin
            @(negedge clock);
            busGrant = requestBus;
            if (beginTransactionOut) begin
                busGrant = 1'b0;
                addr = addressDataOut;
                len = int'(burstSizeOut) + 1;
                burstAddrQ.push_back(addr);
                burstLenQ.push_back(len);
                errored = 1'b0;
                for (int i = 0; i < len && !errored; i++) begin
                    if (i > 0) @(negedge clock);
                    if (beatsSeen == 0) firstBeatCycle = cycleCount;
                    dataValidIn = 1'b1;
                    addressDataIn = addr ^ PATTERN;
                    if (burstAddrQ.size() == 1 && i == errorOnBeat) begin
                        busErrorIn = 1'b1;
                        errored = 1'b1;
                    end
                    addr = addr + 32'd4;
                    beatsSeen++;
                end
                @(negedge clock);
                dataValidIn = 1'b0;
                addressDataIn = 32'd0;
                busErrorIn = 1'b0;
                if (!errored) begin
                    endTransactionIn = 1'b1;
                    @(negedge clock);
                    endTransactionIn = 1'b0;
                end
            end
        end
    end

    // Pixel sink and bus monitor: collects transferred words, counts request cycles and end pulses.
    initial begin : pixelSink
        pixelReady = 1'b0;
        forever begin
            @(negedge clock);
            if (endTransactionOut) endPulseCount++;
            if (requestBus) requestCount++;
            if (pixelValid && firstValidCycle < 0) firstValidCycle = cycleCount;
            pixelReady = readyAll || (readBudget > 0);
            if (pixelValid && pixelReady) begin
                rxQ.push_back(pixelWord);
                if (!readyAll && readBudget > 0) readBudget--;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input ciVector_t v, output logic [31:0] result, output logic done);
        @(negedge clock);
        ciN = v.n; ciStart = v.start; ciCke = v.cke; ciValueA = v.a; ciValueB = v.b;
        #1;
        result = ciResult;
        done = ciDone;
        @(posedge clock);
        #1;
        ciStart = 0; ciCke = 0; ciN = 0; ciValueA = 0; ciValueB = 0;
    endtask

    task automatic ciExec(input logic [31:0] a, input logic [31:0] b, output logic [31:0] result);
        ciVector_t v;
        logic      done;
        v = '{CI_ID, 1'b1, 1'b1, a, b, 1'b1, 32'd0};
        applyStimulus(v, result, done);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        burstAddrQ.delete(); burstLenQ.delete(); rxQ.delete();
        expAddrQ.delete(); expLenQ.delete();
        beatsSeen = 0; firstBeatCycle = -1; firstValidCycle = -1;
        endPulseCount = 0; requestCount = 0; errorOnBeat = -1;
        readyAll = 1'b0; readBudget = 0;
    endtask

    task automatic configure(input logic [31:0] base, input logic [31:0] wpl, input logic [31:0] lines);
        logic [31:0] r;
        ciExec(32'd0, base, r);
        ciExec(32'd1, wpl, r);
        ciExec(32'd2, lines, r);
    endtask

    task automatic waitDone(input string name, input int maxPolls);
        logic [31:0] r;
        logic        busy;
        busy = 1'b1;
        for (int i = 0; i < maxPolls && busy; i++) begin
            ciExec(32'd4, 32'd0, r);
            busy = r[0];
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic buildBursts(input logic [31:0] base, input int wpl, input int lines);
        logic [31:0] addr;
        int          rem;
        int          n;
        addr = base;
        for (int l = 0; l < lines; l++) begin
            rem = wpl;
            while (rem > 0) begin
                n = (rem > 16) ? 16 : rem;
                expAddrQ.push_back(addr);
                expLenQ.push_back(n);
                addr = addr + 32'(4 * n);
                rem = rem - n;
            end
        end
    endtask

    task automatic checkBursts(input string name);
        checkOutput({name, " burst count"}, 32'(burstAddrQ.size()), 32'(expAddrQ.size()));
        for (int i = 0; i < burstAddrQ.size() && i < expAddrQ.size(); i++) begin
            checkOutput($sformatf("%s burst %0d address", name, i), burstAddrQ[i], expAddrQ[i]);
            checkOutput($sformatf("%s burst %0d length", name, i), 32'(burstLenQ[i]), 32'(expLenQ[i]));
        end
    endtask

    task automatic checkFrame(input string name, input logic [31:0] base, input int n);
        int          mism;
        logic [31:0] expWord;
        mism = 0;
        checkOutput({name, " word count"}, 32'(rxQ.size()), 32'(n));
        for (int k = 0; k < rxQ.size() && k < n; k++) begin
            expWord = (base + 32'(4 * k)) ^ PATTERN;
            if (rxQ[k] !== expWord) mism++;
        end
        checkOutput({name, " word order"}, 32'(mism), 32'd0);
    endtask

    initial begin : mainTest
        logic [31:0] r;
        logic        d;
        ciStart = 0; ciCke = 0; ciN = 0; ciValueA = 0; ciValueB = 0; reset = 1'b1;

        vectors[0]  = '{CI_ID,     1'b1, 1'b1, 32'd4,          32'd0,          1'b1, 32'd0};
        vectors[1]  = '{CI_ID,     1'b1, 1'b1, 32'd5,          32'd0,          1'b1, 32'd0};
        vectors[2]  = '{CI_ID,     1'b1, 1'b1, 32'd0,          32'h1234_5677,  1'b1, 32'd0};
        vectors[3]  = '{CI_ID,     1'b1, 1'b1, 32'd5,          32'd0,          1'b1, 32'h1234_5674};
        vectors[4]  = '{8'h2B,     1'b1, 1'b1, 32'd0,          32'hDEAD_BEEF,  1'b0, 32'd0};
        vectors[5]  = '{CI_ID,     1'b1, 1'b0, 32'd5,          32'd0,          1'b0, 32'd0};
        vectors[6]  = '{CI_ID,     1'b0, 1'b1, 32'd5,          32'd0,          1'b0, 32'd0};
        vectors[7]  = '{CI_ID,     1'b1, 1'b1, 32'd6,          32'd0,          1'b1, 32'd0};
        vectors[8]  = '{CI_ID,     1'b1, 1'b1, 32'hFFFF_FFFD,  32'd0,          1'b1, 32'h1234_5674};
        vectors[9]  = '{CI_ID,     1'b1, 1'b1, 32'd2,          32'd0,          1'b1, 32'd0};
        vectors[10] = '{CI_ID,     1'b1, 1'b1, 32'd3,          32'd1,          1'b1, 32'd0};
        vectors[11] = '{CI_ID,     1'b1, 1'b1, 32'd4,          32'd0,          1'b1, 32'd2};
        vectors[12] = '{8'h00,     1'b1, 1'b1, 32'd4,          32'd0,          1'b0, 32'd0};

        // Reset state of every output
        resetDut();
        @(negedge clock);
        checkOutput("reset requestBus", {31'd0, requestBus}, 32'd0);
        checkOutput("reset bus controls", {17'd0, beginTransactionOut, endTransactionOut, readNotWriteOut,
                    byteEnablesOut, burstSizeOut}, 32'd0);
        checkOutput("reset addressDataOut", addressDataOut, 32'd0);
        checkOutput("reset pixelValid", {31'd0, pixelValid}, 32'd0);
        checkOutput("reset pixelWord", pixelWord, 32'd0);
        checkOutput("reset ciDone", {31'd0, ciDone}, 32'd0);
        checkOutput("reset ciResult", ciResult, 32'd0);

        // CI decode and register vectors
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vectors[i], r, d);
            checkOutput($sformatf("ci vector %0d done", i), {31'd0, d}, {31'd0, vectors[i].expDone});
            checkOutput($sformatf("ci vector %0d result", i), r, vectors[i].expResult);
        end
        checkOutput("zero-line start requests", 32'(requestCount), 32'd0);

        // Two-line frame with ready held high
        resetDut();
        readyAll = 1'b1;
        configure(32'h1000, 32'd40, 32'd2);
        ciExec(32'd3, 32'd1, r);
        waitDone("frame busy clears", 2000);
        repeat (40) @(posedge clock);
        buildBursts(32'h1000, 40, 2);
        checkBursts("frame");
        checkFrame("frame", 32'h1000, 80);
        ciExec(32'd4, 32'd0, r);
        checkOutput("frame status", r, 32'd2);
        checkOutput("first pixel latency", 32'(firstValidCycle - firstBeatCycle), 32'd1);

        // Back-pressure: FIFO fills, next burst waits for 8 free entries
        resetDut();
        configure(32'h2000, 32'd40, 32'd1);
        ciExec(32'd3, 32'd1, r);
        repeat (150) @(posedge clock);
        checkOutput("stall burst count", 32'(burstAddrQ.size()), 32'd2);
        checkOutput("stall pixelValid", {31'd0, pixelValid}, 32'd1);
        readBudget = 7;
        repeat (40) @(posedge clock);
        checkOutput("seven free burst count", 32'(burstAddrQ.size()), 32'd2);
        readBudget = 1;
        repeat (40) @(posedge clock);
        checkOutput("eight free burst count", 32'(burstAddrQ.size()), 32'd3);
        if (burstLenQ.size() > 2) checkOutput("tail burst length", 32'(burstLenQ[2]), 32'd8);
        readyAll = 1'b1;
        waitDone("stall busy clears", 2000);
        repeat (40) @(posedge clock);
        checkFrame("stall", 32'h2000, 40);

        // Bus error on the third beat of the first burst
        resetDut();
        readyAll = 1'b1;
        errorOnBeat = 2;
        configure(32'h3000, 32'd40, 32'd1);
        ciExec(32'd3, 32'd1, r);
        repeat (100) @(posedge clock);
        checkOutput("error end pulses", 32'(endPulseCount), 32'd1);
        ciExec(32'd4, 32'd0, r);
        checkOutput("error status", r, 32'd4);
        checkOutput("error burst count", 32'(burstAddrQ.size()), 32'd1);
        checkFrame("error", 32'h3000, 2);

        // Start while busy is ignored; zero-line start finishes immediately
        resetDut();
        readyAll = 1'b1;
        configure(32'h4000, 32'd40, 32'd1);
        ciExec(32'd3, 32'd1, r);
        repeat (5) @(posedge clock);
        ciExec(32'd3, 32'd1, r);
        waitDone("restart busy clears", 2000);
        repeat (40) @(posedge clock);
        buildBursts(32'h4000, 40, 1);
        checkBursts("restart");
        checkFrame("restart", 32'h4000, 40);
        ciExec(32'd5, 32'd0, r);
        checkOutput("restart base", r, 32'h4000);
        ciExec(32'd2, 32'd0, r);
        requestCount = 0;
        ciExec(32'd3, 32'd1, r);
        ciExec(32'd4, 32'd0, r);
        checkOutput("zero lines status", r, 32'd2);
        repeat (30) @(posedge clock);
        checkOutput("zero lines requests", 32'(requestCount), 32'd0);

        // Abort during WAIT_DATA: burst completes, FIFO flushed
        resetDut();
        configure(32'h5000, 32'd40, 32'd1);
        ciExec(32'd3, 32'd1, r);
        for (int i = 0; i < 300 && beatsSeen < 4; i++) @(posedge clock);
        ciExec(32'd3, 32'd2, r);
        repeat (60) @(posedge clock);
        @(negedge clock);
        checkOutput("abort pixelValid", {31'd0, pixelValid}, 32'd0);
        checkOutput("abort beats", 32'(beatsSeen), 32'd16);
        checkOutput("abort burst count", 32'(burstAddrQ.size()), 32'd1);
        checkOutput("abort words out", 32'(rxQ.size()), 32'd0);
        ciExec(32'd4, 32'd0, r);
        checkOutput("abort status", r, 32'd0);

        // Address wrap past 2^32
        resetDut();
        readyAll = 1'b1;
        configure(32'hFFFF_FFF8, 32'd4, 32'd2);
        ciExec(32'd3, 32'd1, r);
        waitDone("wrap busy clears", 1000);
        repeat (20) @(posedge clock);
        buildBursts(32'hFFFF_FFF8, 4, 2);
        checkBursts("wrap");
        checkFrame("wrap", 32'hFFFF_FFF8, 8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
